// File: rtl/max_unpool1d_pkg.sv
// max_unpool1d_pkg: shared pooling types, index-width helper and parameter-check macro.
package max_unpool1d_pkg;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`define POOL_PARAM_CHECK(name, cond, msg) if (!(cond)) begin : name $error(msg); end

// File: rtl/max_unpool1d.sv
// max_unpool1d: expands (value, argmax offset) beats into KERNEL_SIZE-wide zero-filled windows.
// Optional MAX_UNPOOL1D_INDEX_CHECK_EN adds a sticky out-of-range offset flag on index_err.
module max_unpool1d
    import max_unpool1d_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0        = 8,
    parameter int DATA_IN_0_PRECISION_1        = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 4,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 1,
    parameter int KERNEL_SIZE                  = 2,
    parameter int STRIDE                       = 2,
    parameter int DATA_OUT_0_PRECISION_0       = 8,
    parameter int DATA_OUT_0_PRECISION_1       = 3,
    parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int IDX_W                        = idx_width(KERNEL_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic [IDX_W-1:0]                  data_in_1,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready,
    output logic                              data_out_0_last,
    output logic                              index_err
);

    localparam int EW = idx_width(DATA_IN_0_TENSOR_SIZE_DIM_0);
    localparam int RW = idx_width(DATA_IN_0_TENSOR_SIZE_DIM_1);

    `POOL_PARAM_CHECK(chk_kernel, KERNEL_SIZE >= 2, "KERNEL_SIZE must be >= 2")
    `POOL_PARAM_CHECK(chk_stride, STRIDE == KERNEL_SIZE, "STRIDE must equal KERNEL_SIZE")
    `POOL_PARAM_CHECK(chk_prec0, DATA_OUT_0_PRECISION_0 == DATA_IN_0_PRECISION_0, "output width must equal input width")
    `POOL_PARAM_CHECK(chk_prec1, DATA_OUT_0_PRECISION_1 == DATA_IN_0_PRECISION_1, "output fraction must equal input fraction")
    `POOL_PARAM_CHECK(chk_dim0, DATA_OUT_0_TENSOR_SIZE_DIM_0 == DATA_IN_0_TENSOR_SIZE_DIM_0 * KERNEL_SIZE, "output row length must be DIM_0*KERNEL_SIZE")

    state_t                           state;
    logic [IDX_W-1:0]                 k;
    logic [IDX_W-1:0]                 offset;
    logic [EW-1:0]                    e;
    logic [RW-1:0]                    r;
    logic [DATA_IN_0_PRECISION_0-1:0] held;
    logic                             last_k;
    logic                             last_e;
    logic                             out_fire;
    logic                             in_fire;

    assign last_k   = k == IDX_W'(KERNEL_SIZE - 1);
    assign last_e   = e == EW'(DATA_IN_0_TENSOR_SIZE_DIM_0 - 1);
    assign out_fire = (state == EMIT) && data_out_0_ready;
    // only the last slot's handshake can open the input in the same cycle
    assign data_in_0_ready  = rst && ((state == IDLE) || (last_k && out_fire));
    assign in_fire          = data_in_0_valid && data_in_0_ready;
    assign data_out_0_valid = state == EMIT;
    assign data_out_0       = (data_out_0_valid && k == offset) ? held : '0;
    assign data_out_0_last  = data_out_0_valid && last_k && last_e;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            k      <= '0;
            e      <= '0;
            r      <= '0;
            held   <= '0;
            offset <= '0;
        end else begin
            if (out_fire) begin
                if (!last_k) begin
                    k <= k + 1'b1;
                end else begin
                    k <= '0;
                    e <= last_e ? '0 : e + 1'b1;
                    if (last_e)
                        r <= (r == RW'(DATA_IN_0_TENSOR_SIZE_DIM_1 - 1)) ? '0 : r + 1'b1;
                    if (!in_fire)
                        state <= IDLE;
                end
            end
            if (in_fire) begin
                held   <= data_in_0;
                offset <= data_in_1;
                k      <= '0;
                state  <= EMIT;
            end
        end
    end

`ifdef MAX_UNPOOL1D_INDEX_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            index_err <= 1'b0;
        else if (in_fire && int'(data_in_1) >= KERNEL_SIZE)
            index_err <= 1'b1;
    end
`else
    assign index_err = 1'b0;
`endif

endmodule

// File: doc/max_unpool1d.md
Name: max_unpool1d

Overview:
- Inverse of the 1-D max-pool stage: rebuilds the pre-pool 1-D stream from pooled values plus their argmax offsets.
- Each accepted pooled beat (value, offset within window) expands to KERNEL_SIZE output beats. The value is placed at the offset slot; every other slot is zero.
- Sits in decoder/upsampling paths downstream of a pooling stage that exports indices. Uses the same valid/ready streaming interface as the rest of the pooling layers.

Parameters:
- DATA_IN_0_PRECISION_0, 8, value word width.
- DATA_IN_0_PRECISION_1, 3, fractional bits; passed through, not used arithmetically.
- DATA_IN_0_TENSOR_SIZE_DIM_0, 4, pooled elements per row.
- DATA_IN_0_TENSOR_SIZE_DIM_1, 1, rows per tensor.
- KERNEL_SIZE, 2, window size, >=2.
- STRIDE, 2, must equal KERNEL_SIZE (non-overlapping windows); elaboration assert otherwise.
- DATA_OUT_0_PRECISION_0, 8, must equal DATA_IN_0_PRECISION_0 (assert).
- DATA_OUT_0_PRECISION_1, 3, must equal DATA_IN_0_PRECISION_1 (assert).
- DATA_OUT_0_TENSOR_SIZE_DIM_0, 8, must equal DATA_IN_0_TENSOR_SIZE_DIM_0*KERNEL_SIZE (assert).
- IDX_W, $clog2(KERNEL_SIZE), derived; offset width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- data_in_0  in  DATA_IN_0_PRECISION_0  pooled value.
- data_in_1  in  IDX_W  argmax offset within window.
- data_in_0_valid  in  1  input beat valid; covers data_in_0 and data_in_1.
- data_in_0_ready  out  1  input beat accepted when valid&&ready.
- data_out_0  out  DATA_OUT_0_PRECISION_0  unpooled value.
- data_out_0_valid  out  1  output valid.
- data_out_0_ready  in  1  downstream ready.
- data_out_0_last  out  1  last beat of the current row.
- index_err  out  1  sticky out-of-range offset flag; tied to 0 when the macro is undefined.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, slot counter k=0, element counter e=0, row counter r=0, held value/offset=0. All outputs 0 except data_in_0_ready=1 after release.
- IDLE: data_in_0_ready=1, data_out_0_valid=0. On input handshake: latch value and offset, k=0, go to EMIT.
- EMIT:
  - data_out_0_valid=1.
  - data_out_0 = held value if k==offset, else 0.
  - data_out_0_last = (k==KERNEL_SIZE-1) && (e==DATA_IN_0_TENSOR_SIZE_DIM_0-1).
- Output handshake with k<KERNEL_SIZE-1: k++.
- Output handshake with k==KERNEL_SIZE-1:
  - k=0.
  - e wraps to 0 at DATA_IN_0_TENSOR_SIZE_DIM_0-1, else e++.
  - On e wrap, r wraps to 0 at DATA_IN_0_TENSOR_SIZE_DIM_1-1, else r++.
  - If an input handshake occurs in the same cycle, latch the new beat and stay in EMIT. Otherwise go to IDLE.
- data_in_0_ready = (state==IDLE) || (state==EMIT && k==KERNEL_SIZE-1 && data_out_0_ready). Combinational path from data_out_0_ready to data_in_0_ready only.
- Latency: input handshake at cycle t -> first output beat valid at t+1. Sustained throughput: one output beat per cycle, one input beat per KERNEL_SIZE cycles.
- Backpressure: while data_out_0_ready=0, data_out_0, data_out_0_valid and data_out_0_last hold stable and k does not advance.
- Offset >= KERNEL_SIZE (possible only when KERNEL_SIZE is not a power of two): matches no slot, so the window emits all zeros.
- Reset mid-window: beat in flight discarded; no partial window resumes.

Optional Feature:
- Macro: MAX_UNPOOL1D_INDEX_CHECK_EN.
- Defined: at input handshake, data_in_1 >= KERNEL_SIZE sets index_err=1. It stays set until reset. The window is still emitted as all zeros.
- Undefined: no comparator; index_err is constant 0; datapath behaviour is identical.

Decomposition:
- Shared pooling package holds:
  - state enum {IDLE, EMIT}.
  - index-width helper function (clog2 with minimum 1).
  - parameter-consistency check macros used by both the pool and unpool blocks.
- No sub-module: the slot compare is a single equality. Counters and FSM stay in one always_ff.

Test Plan:
- KERNEL_SIZE=2, ready=1, inputs (5,1),(7,0) back-to-back -> outputs 0,5,7,0 on consecutive cycles; input ready pulses every 2nd cycle.
- KERNEL_SIZE=4, DIM_0=2, inputs (-3,2),(9,3) -> outputs 0,0,-3,0,0,0,0,9; data_out_0_last high only on the 8th beat.
- Backpressure: data_out_0_ready toggles 1,0,0,1 during window (5,1) -> data_out_0 stable while ready=0; data_in_0_ready=0 until last-slot handshake.
- KERNEL_SIZE=3, offset=3, macro defined -> outputs 0,0,0; index_err=1 until reset. Same stimulus without the macro -> 0,0,0 and index_err=0.
- Assert rst low after the 1st of 4 output beats -> outputs go invalid immediately. After release: IDLE, ready=1, next window starts at k=0, e=0.
- DIM_0=4, DIM_1=2, 8 random inputs -> data_out_0_last high at output beats 8 and 16 (KERNEL_SIZE=2) and nowhere else.
